// File: rtl/fiber_tx_frame_arb_if.sv
// AXI-Stream style frame channel shared by the cmd, ddc and TX-FIFO sides of the arbiter.
interface fiber_tx_frame_arb_if #(
    parameter int DW = 64
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/fiber_tx_frame_arb.sv
// Frame-atomic arbiter feeding the Aurora TX FIFO: cmd frames beat ddc frames at frame
// boundaries only, and a watchdog closes any granted frame whose source goes quiet.
module fiber_tx_frame_arb #(
    parameter int          DW          = 64,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1024,
    parameter logic [DW-1:0] PAD_WORD  = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    fiber_tx_frame_arb_if.slave          cmd,
    fiber_tx_frame_arb_if.slave          ddc,
    fiber_tx_frame_arb_if.master         m,
    output logic [7:0]                   m_tkeep,
    output logic [15:0]                  cmd_frame_cnt,
    output logic [15:0]                  ddc_frame_cnt,
    output logic [15:0]                  abort_cnt,
    output logic                         abort_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_CMD = 2'd1,
        GRANT_DDC = 2'd2,
        PAD       = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [15:0]     wd_r;
    logic [15:0]     wd_inc_val_s;
    logic            wd_clr_s;
    logic            wd_inc_s;
    logic            load_pad_s;
    logic [DW-1:0]   m_tdata_r;
    logic            m_tvalid_r;
    logic            m_tlast_r;
    logic [15:0]     cmd_frame_cnt_r;
    logic [15:0]     ddc_frame_cnt_r;
    logic [15:0]     abort_cnt_r;
    logic            abort_pulse_r;
    logic            slot_free_s;
    logic            is_cmd_s;
    logic            granted_s;
    logic            src_valid_s;
    logic            src_last_s;
    logic [DW-1:0]   src_data_s;
    logic            accept_s;

    // The output slot can take a new word when it is empty or being drained this cycle.
    assign slot_free_s  = !m_tvalid_r || m.tready;
    assign is_cmd_s     = (state_r == GRANT_CMD);
    assign granted_s    = (state_r == GRANT_CMD) || (state_r == GRANT_DDC);
    assign src_valid_s  = is_cmd_s ? cmd.tvalid : ddc.tvalid;
    assign src_last_s   = is_cmd_s ? cmd.tlast  : ddc.tlast;
    assign src_data_s   = is_cmd_s ? cmd.tdata  : ddc.tdata;
    assign accept_s     = granted_s && slot_free_s && src_valid_s;
    assign wd_inc_val_s = wd_r + 16'd1;

    assign cmd.tready    = (state_r == GRANT_CMD) && slot_free_s;
    assign ddc.tready    = (state_r == GRANT_DDC) && slot_free_s;
    assign m.tdata       = m_tdata_r;
    assign m.tvalid      = m_tvalid_r;
    assign m.tlast       = m_tlast_r;
    assign m_tkeep       = 8'hFF;
    assign cmd_frame_cnt = cmd_frame_cnt_r;
    assign ddc_frame_cnt = ddc_frame_cnt_r;
    assign abort_cnt     = abort_cnt_r;
    assign abort_pulse   = abort_pulse_r;

    // Arbiter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, watchdog control and pad injection.
    always_comb begin
        state_s    = state_r;
        wd_clr_s   = 1'b0;
        wd_inc_s   = 1'b0;
        load_pad_s = 1'b0;
        case (state_r)
            IDLE: begin
                wd_clr_s = 1'b1;
                if (enable && cmd.tvalid) begin
                    state_s = GRANT_CMD;
                end else if (enable && ddc.tvalid) begin
                    state_s = GRANT_DDC;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT_CMD, GRANT_DDC: begin
                if (accept_s) begin
                    // A beat on the timeout cycle still wins: the counter just clears.
                    wd_clr_s = 1'b1;
                    if (src_last_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end else if (!src_valid_s) begin
                    wd_inc_s = 1'b1;
                    if (wd_inc_val_s == TIMEOUT_CYC) begin
                        state_s = PAD;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            PAD: begin
                if (slot_free_s) begin
                    load_pad_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s    = PAD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Watchdog: counts source-idle cycles inside a granted frame only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r <= 16'd0;
        end else if (wd_clr_s) begin
            wd_r <= 16'd0;
        end else if (wd_inc_s) begin
            wd_r <= wd_inc_val_s;
        end else begin
            wd_r <= wd_r;
        end
    end

    // Single output register stage; holds its word while the FIFO back-pressures.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata_r  <= '0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= src_data_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= src_last_s;
        end else if (load_pad_s) begin
            m_tdata_r  <= PAD_WORD;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= 1'b1;
        end else if (m.tready) begin
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
        end else begin
            m_tvalid_r <= m_tvalid_r;
            m_tlast_r  <= m_tlast_r;
        end
    end

    // Frame/abort statistics; counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_frame_cnt_r <= 16'd0;
            ddc_frame_cnt_r <= 16'd0;
            abort_cnt_r     <= 16'd0;
            abort_pulse_r   <= 1'b0;
        end else begin
            abort_pulse_r <= load_pad_s;
            if (accept_s && src_last_s && is_cmd_s) begin
                cmd_frame_cnt_r <= cmd_frame_cnt_r + 16'd1;
            end else begin
                cmd_frame_cnt_r <= cmd_frame_cnt_r;
            end
            if (accept_s && src_last_s && !is_cmd_s) begin
                ddc_frame_cnt_r <= ddc_frame_cnt_r + 16'd1;
            end else begin
                ddc_frame_cnt_r <= ddc_frame_cnt_r;
            end
            if (load_pad_s) begin
                abort_cnt_r <= abort_cnt_r + 16'd1;
            end else begin
                abort_cnt_r <= abort_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_fiber_tx_frame_arb.sv
// Scoreboard bench for fiber_tx_frame_arb: stimulus pushes expected output words,
// a negedge monitor pops and compares every word the arbiter hands to the FIFO.
module tb_fiber_tx_frame_arb;

    localparam logic [63:0] PAD = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [15:0] TO  = 16'd8;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    fiber_tx_frame_arb_if #(.DW(64)) cmd_if ();
    fiber_tx_frame_arb_if #(.DW(64)) ddc_if ();
    fiber_tx_frame_arb_if #(.DW(64)) m_if ();

    logic [7:0]  m_tkeep;
    logic [15:0] cmd_frame_cnt, ddc_frame_cnt, abort_cnt;
    logic        abort_pulse;

    fiber_tx_frame_arb #(.DW(64), .TIMEOUT_CYC(TO), .PAD_WORD(PAD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cmd           (cmd_if),
        .ddc           (ddc_if),
        .m             (m_if),
        .m_tkeep       (m_tkeep),
        .cmd_frame_cnt (cmd_frame_cnt),
        .ddc_frame_cnt (ddc_frame_cnt),
        .abort_cnt     (abort_cnt),
        .abort_pulse   (abort_pulse)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        pad;
    } exp_t;

    exp_t exp_q[$];
    int   dq[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   last_cyc  = 0;
    int   pulse_cnt = 0;
    logic        stall  = 1'b0;
    logic [63:0] held_d = 64'd0;
    logic        held_l = 1'b0;
    bit          done   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_words(input logic [63:0] base, input int n, input bit last_on_final);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.data = base + 64'(i);
            e.last = last_on_final && (i == n - 1);
            e.pad  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_pad();
        exp_t e;
        e.data = PAD;
        e.last = 1'b1;
        e.pad  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic set_src(input bit is_cmd, input logic v, input logic [63:0] d, input logic l);
        if (is_cmd) begin
            cmd_if.tvalid = v; cmd_if.tdata = d; cmd_if.tlast = l;
        end else begin
            ddc_if.tvalid = v; ddc_if.tdata = d; ddc_if.tlast = l;
        end
    endtask

    // Drives n words; stop_at>0 abandons the frame (valid low) before word stop_at.
    task automatic send(input bit is_cmd, input int n, input logic [63:0] base, input int stop_at);
        for (int i = 0; i < n; i++) begin
            bit got;
            int budget;
            if (stop_at > 0 && i == stop_at) break;
            set_src(is_cmd, 1'b1, base + 64'(i), (i == n - 1));
            got = 1'b0;
            budget = 0;
            while (!got && budget < 3000) begin
                @(negedge clk);
                if (is_cmd ? cmd_if.tready : ddc_if.tready) got = 1'b1;
                @(posedge clk); #1;
                budget++;
            end
            if (!got) begin
                total_cnt++;
                $display("FAIL send_timeout: word %0d of stream %0d never accepted", i, is_cmd);
                break;
            end
        end
        set_src(is_cmd, 1'b0, 64'd0, 1'b0);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: compares each transferred word and checks hold-stability under back-pressure.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 64'(m_if.tvalid), 64'd1);
                check("hold_data", m_if.tdata, held_d);
                check("hold_last", 64'(m_if.tlast), 64'(held_l));
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_word: got %h expected none", m_if.tdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", m_if.tdata, e.data);
                    check("out_last", 64'(m_if.tlast), 64'(e.last));
                    check("abort_pulse_on_pad", 64'(abort_pulse), 64'(e.pad));
                    check("tkeep", 64'(m_tkeep), 64'hFF);
                end
                dq.push_back(cyc - last_cyc);
                last_cyc = cyc;
            end
            if (abort_pulse) pulse_cnt++;
            stall  = m_if.tvalid && !m_if.tready;
            held_d = m_if.tdata;
            held_l = m_if.tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int ones;
        logic [31:0] pat;
        m_if.tready = 1'b1;
        set_src(1'b1, 1'b0, 64'd0, 1'b0);
        set_src(1'b0, 1'b0, 64'd0, 1'b0);
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tdata", m_if.tdata, 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_cmd_tready", 64'(cmd_if.tready), 64'd0);
        check("rst_ddc_tready", 64'(ddc_if.tready), 64'd0);
        check("rst_counters", {16'd0, cmd_frame_cnt, ddc_frame_cnt, abort_cnt}, 64'd0);
        check("rst_abort_pulse", 64'(abort_pulse), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single 4-word ddc frame; last word visible one cycle after its acceptance.
        push_words(64'h1000, 4, 1'b1);
        send(1'b0, 4, 64'h1000, 0);
        check("t1_lat_valid", 64'(m_if.tvalid), 64'd1);
        check("t1_lat_last", 64'(m_if.tlast), 64'd1);
        check("t1_lat_data", m_if.tdata, 64'h1003);
        wait_drain();
        check("t1_ddc_cnt", 64'(ddc_frame_cnt), 64'd1);
        check("t1_cmd_cnt", 64'(cmd_frame_cnt), 64'd0);

        // 2: simultaneous request, cmd first, one bubble before ddc.
        push_words(64'h2000, 3, 1'b1);
        push_words(64'h3000, 3, 1'b1);
        fork
            send(1'b1, 3, 64'h2000, 0);
            send(1'b0, 3, 64'h3000, 0);
        join
        wait_drain();
        check("t2_bubble", 64'(dq[dq.size() - 3]), 64'd2);
        check("t2_cmd_cnt", 64'(cmd_frame_cnt), 64'd1);
        check("t2_ddc_cnt", 64'(ddc_frame_cnt), 64'd2);

        // 3: cmd arrives during word 2 of a long ddc frame; ddc stays contiguous.
        n0 = dq.size();
        push_words(64'h4000, 265, 1'b1);
        push_words(64'h5000, 3, 1'b1);
        fork
            send(1'b0, 265, 64'h4000, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                send(1'b1, 3, 64'h5000, 0);
            end
        join
        wait_drain();
        ones = 0;
        for (int k = n0 + 1; k < dq.size(); k++) if (dq[k] == 1) ones++;
        check("t3_word_count", 64'(dq.size() - n0), 64'd268);
        check("t3_contiguous", 64'(ones), 64'd266);
        check("t3_cmd_bubble", 64'(dq[n0 + 265]), 64'd2);
        check("t3_cmd_cnt", 64'(cmd_frame_cnt), 64'd2);
        check("t3_ddc_cnt", 64'(ddc_frame_cnt), 64'd3);

        // 4: ddc stalls after word 2; 8 idle grant cycles, one PAD cycle, then the pad word.
        push_words(64'h6000, 2, 1'b0);
        push_pad();
        send(1'b0, 4, 64'h6000, 2);
        wait_drain();
        check("t4_pad_delay", 64'(dq[dq.size() - 1]), 64'(TO) + 64'd1);
        check("t4_abort_cnt", 64'(abort_cnt), 64'd1);
        check("t4_pulse_cycles", 64'(pulse_cnt), 64'd1);
        check("t4_ddc_cnt", 64'(ddc_frame_cnt), 64'd3);
        check("t4_cmd_cnt", 64'(cmd_frame_cnt), 64'd2);

        // 5: 16-word cmd frame under a fixed irregular m_tready pattern.
        pat = 32'b1011_0010_1100_0111_0100_1101_1001_0110;
        push_words(64'h7000, 16, 1'b1);
        done = 1'b0;
        fork
            begin
                send(1'b1, 16, 64'h7000, 0);
                done = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!done) begin
                    m_if.tready = pat[k % 32];
                    k++;
                    @(posedge clk); #1;
                end
                m_if.tready = 1'b1;
            end
        join
        wait_drain();
        check("t5_cmd_cnt", 64'(cmd_frame_cnt), 64'd3);
        check("t5_no_abort", 64'(abort_cnt), 64'd1);

        // 6: async reset while word 5 of a 10-word frame is offered.
        push_words(64'h8000, 3, 1'b0);
        send(1'b0, 10, 64'h8000, 4);
        set_src(1'b0, 1'b1, 64'h8004, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_tvalid", 64'(m_if.tvalid), 64'd0);
        check("t6_tdata", m_if.tdata, 64'd0);
        check("t6_tlast", 64'(m_if.tlast), 64'd0);
        check("t6_ddc_tready", 64'(ddc_if.tready), 64'd0);
        check("t6_counters", {16'd0, cmd_frame_cnt, ddc_frame_cnt, abort_cnt}, 64'd0);
        check("t6_partial_seen", 64'(exp_q.size()), 64'd0);
        set_src(1'b0, 1'b0, 64'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // enable low blocks the grant; once raised the frame goes out from IDLE.
        enable = 1'b0;
        push_words(64'h9000, 2, 1'b1);
        fork
            send(1'b1, 2, 64'h9000, 0);
            begin
                repeat (6) @(posedge clk);
                #1;
                check("en_blocked_tready", 64'(cmd_if.tready), 64'd0);
                check("en_blocked_queue", 64'(exp_q.size()), 64'd2);
                enable = 1'b1;
            end
        join
        wait_drain();
        check("post_rst_cmd_cnt", 64'(cmd_frame_cnt), 64'd1);
        check("post_rst_ddc_cnt", 64'(ddc_frame_cnt), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
